mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter in front of the SoC data bus, which serves the data RAM and the IO page.
- Master 0 is the pipelined core's data port. It has absolute priority, no stall and zero added latency.
- Master 1 is a secondary requester, such as a debug loader or DMA. It uses a req/gnt handshake and only gets bus cycles in which the core issues no strobe.
- Sits between the core/secondary master and the RAM/IO decode. Tracks master 1's outstanding read and flags master-1 starvation.

Parameters:
- ADDR_WIDTH, 14, bus byte-address width. Bit ADDR_WIDTH-1 is the IO select; bits [1:0] are ignored.
- STARVE_LIMIT, 255, number of consecutive ungranted m1_req cycles before m1_starved asserts.
- CNT_WIDTH, 8, starvation counter width. Must satisfy STARVE_LIMIT <= 2**CNT_WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_addr  in  ADDR_WIDTH  core address.
- m0_wdata  in  32  core write data.
- m0_mask  in  4  core byte mask (read and write).
- m0_rstrb  in  1  core read strobe.
- m0_wstrb  in  1  core write strobe.
- m0_rdata  out  32  core read data, equal to s_rdata.
- m1_req  in  1  master-1 request. Held with all m1_* fields stable until m1_gnt.
- m1_we  in  1  1 = write, 0 = read.
- m1_addr  in  ADDR_WIDTH  master-1 address.
- m1_wdata  in  32  master-1 write data.
- m1_mask  in  4  master-1 byte mask.
- m1_gnt  out  1  access issued to the bus this cycle (combinational).
- m1_rvalid  out  1  master-1 read data valid (registered).
- m1_rdata  out  32  master-1 read data, held until the next m1_rvalid.
- m1_starved  out  1  starvation flag (registered).
- s_addr  out  ADDR_WIDTH  bus address to RAM/IO decode.
- s_wdata  out  32  bus write data.
- s_mask  out  4  bus byte mask.
- s_rstrb  out  1  bus read strobe.
- s_wstrb  out  1  bus write strobe.
- s_rdata  in  32  bus read data; 1-cycle synchronous latency (RAM and latched IO).

Behaviour:
- Definition: m0_active = m0_rstrb | m0_wstrb.
- Master-0 path:
  - When m0_active, s_* = m0_* combinationally in the same cycle.
  - m0_rdata = s_rdata unconditionally. The core sees its usual 1-cycle read latency.
- Master-1 grant (m1_gnt = m1_req & !m0_active & rst):
  - While m1_gnt, s_addr/s_wdata/s_mask = m1_*, s_wstrb = m1_we, s_rstrb = !m1_we.
  - Back-to-back grants are allowed every free cycle.
- Idle bus: when neither master is driving, s_rstrb = s_wstrb = 0 and s_addr/s_wdata/s_mask = m0_*.
- Read-tracking FSM:
  - States: IDLE and RD_PEND.
  - Any state -> RD_PEND on (m1_gnt & !m1_we). Otherwise -> IDLE.
  - m1_rvalid = (state == RD_PEND).
  - m1_rdata: captured from s_rdata in each RD_PEND cycle and exposed combinationally from s_rdata during that cycle; the register holds the value afterwards.
  - A new m1 grant in an RD_PEND cycle is legal (pipelined), so a continuous read stream gives rvalid every cycle.
- Core read in the cycle after an m1 read grant: the s_rdata stream stays cycle-aligned. The core's data appears one cycle later, so there is no conflict.
- Starvation counter:
  - Increments each cycle with m1_req & !m1_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 on any m1_gnt, or on a cycle with !m1_req.
  - m1_starved is registered: it is 1 in the cycle after the counter has reached STARVE_LIMIT, and clears the cycle after a grant or after req drops.
- Write acknowledgement: a write is complete at m1_gnt; there is no write response.
- Reset:
  - Asynchronously forces state = IDLE, m1_rvalid = 0, m1_rdata = 0, counter = 0, m1_starved = 0.
  - While rst is low: m1_gnt = 0 and s_rstrb = s_wstrb = 0, even if m0 strobes are high.
  - Reset asserted mid-read drops the pending rvalid; master 1 must reissue.
- Illegal use: master 1 changing fields or dropping req before gnt is undefined. The bench flags it as an assertion, not a design error.

Decomposition:
- Shared package mem_bus_pkg:
  - FSM state encoding: ST_IDLE = 1'b0, ST_RD_PEND = 1'b1.
  - IO_SEL_BIT = ADDR_WIDTH-1.
  - Bus field widths: DATA_W = 32, MASK_W = 4.
- One sub-module: starve_counter (saturating counter with clear and registered flag), parameterised by STARVE_LIMIT/CNT_WIDTH.
- The mux and FSM stay in the top-level.

Test Plan:
- m0 streams 10 reads at 0x0010..0x0034 while m1_req is held (read 0x0100) -> m1_gnt = 0 throughout; s_addr tracks m0; m0_rdata matches RAM one cycle after each strobe.
- m0 idle, m1 writes 0xDEADBEEF to 0x0200 with mask 1111, then reads 0x0200 -> gnt on first free cycle; rvalid the cycle after the read grant; m1_rdata = 0xDEADBEEF, held until the next rvalid.
- m1 issues reads to 0x0000, 0x0004, 0x0008 back-to-back with m0 idle, then m0 issues a read in the cycle after the last grant -> three consecutive rvalids with the correct words; core receives its own data one cycle later.
- STARVE_LIMIT = 4: m0 strobes continuously for 8 cycles with m1_req high -> m1_starved rises after the 4th ungranted cycle; clears the cycle after m0 stops and m1 is granted.
- Assert rst low in the RD_PEND cycle, with m0_wstrb = 1 -> m1_rvalid = 0 immediately; s_wstrb = 0; after release, state = IDLE and the counter = 0.
- m1 write to the IO page (0x2001, mask 0010, data 0x0000A500) with m0 idle -> s_wstrb = 1 with IO bit set; s_wdata[15:8] = 0xA5; no rvalid.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the two-master data-bus arbiter.
// Contents:
//   DATA_W / MASK_W   bus data and byte-mask widths
//   ADDR_WIDTH_DEF    default bus byte-address width
//   IO_SEL_BIT        address bit that selects the IO page
//   rd_state_e        master-1 read-tracking FSM states
//   is_io_addr()      helper that tests the IO select bit
// ---------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int DATA_W         = 32;
  localparam int MASK_W         = 4;
  localparam int ADDR_WIDTH_DEF = 14;
  localparam int IO_SEL_BIT     = ADDR_WIDTH_DEF - 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_PEND = 1'b1
  } rd_state_e;

  function automatic logic is_io_addr(input logic [ADDR_WIDTH_DEF-1:0] addr);
    return addr[IO_SEL_BIT];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles the core port (m0_*), the secondary-master port (m1_*) and the
// downstream bus towards the RAM/IO decode (s_*).
// Modports:
//   slave  - arbiter view: takes both master requests and s_rdata,
//            drives read data/grant/status back and the bus outward
//   master - requester/bus-model view, the mirror image of slave
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
);

  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_W-1:0]     m0_wdata;
  logic [MASK_W-1:0]     m0_mask;
  logic                  m0_rstrb;
  logic                  m0_wstrb;
  logic [DATA_W-1:0]     m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_W-1:0]     m1_wdata;
  logic [MASK_W-1:0]     m1_mask;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_W-1:0]     m1_rdata;
  logic                  m1_starved;

  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_W-1:0]     s_wdata;
  logic [MASK_W-1:0]     s_mask;
  logic                  s_rstrb;
  logic                  s_wstrb;
  logic [DATA_W-1:0]     s_rdata;

  modport slave (
    input  m0_addr, m0_wdata, m0_mask, m0_rstrb, m0_wstrb,
    output m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    output m1_gnt, m1_rvalid, m1_rdata, m1_starved,
    output s_addr, s_wdata, s_mask, s_rstrb, s_wstrb,
    input  s_rdata
  );

  modport master (
    output m0_addr, m0_wdata, m0_mask, m0_rstrb, m0_wstrb,
    input  m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_starved,
    input  s_addr, s_wdata, s_mask, s_rstrb, s_wstrb,
    output s_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
// Counts consecutive cycles in which master 1 requests but is not granted,
// saturating at STARVE_LIMIT, and raises a registered starvation flag.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   i_req      master-1 request
//   i_gnt      master-1 grant this cycle
//   o_starved  registered starvation flag
// ---------------------------------------------------------------------------
module starve_counter #(
  parameter int STARVE_LIMIT = 255,
  parameter int CNT_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_starved
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_waiting;
  logic                 r_starved;

  assign w_waiting = i_req & ~i_gnt;

  // Any grant or a cycle without a request ends the starvation run.
  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_waiting) begin
      w_cnt_next = '0;
    end else if (r_cnt < LIMIT) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // The flag is registered alongside the counter, so it shows up in the
  // cycle right after the counter lands on the limit and drops one cycle
  // after the run is broken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_starved <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_starved <= w_waiting && (w_cnt_next == LIMIT);
    end
  end

  assign o_starved = r_starved;

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Two-master arbiter in front of the SoC data bus (data RAM + IO page).
// Master 0 (core data port) has absolute priority with no stall and no
// added latency. Master 1 is granted only in cycles where the core issues
// no strobe; its single outstanding read is tracked and starvation flagged.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   mem_bus_arbiter_if.slave: m0_* core port, m1_* secondary port,
//         s_* bus towards RAM/IO decode (1-cycle read latency)
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 255,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.slave    bus
);

  logic                  w_m0_active;
  logic                  w_m1_gnt;
  logic                  w_m1_rd_gnt;
  logic                  w_m1_rvalid;
  logic [ADDR_WIDTH-1:0] w_s_addr;
  logic [DATA_W-1:0]     w_s_wdata;
  logic [MASK_W-1:0]     w_s_mask;
  logic                  w_s_rstrb;
  logic                  w_s_wstrb;
  logic                  w_starved;
  rd_state_e             r_state;
  rd_state_e             w_state_next;
  logic [DATA_W-1:0]     r_m1_rdata;

  assign w_m0_active = bus.m0_rstrb | bus.m0_wstrb;
  // Gating with rst keeps the bus quiet while the block is held in reset.
  assign w_m1_gnt    = bus.m1_req & ~w_m0_active & rst;
  assign w_m1_rd_gnt = w_m1_gnt & ~bus.m1_we;

  // Bus mux: core first, then master 1; an idle bus still carries the
  // core's address/data fields so the core path never passes through
  // extra select logic beyond the strobes.
  always_comb begin
    w_s_addr  = bus.m0_addr;
    w_s_wdata = bus.m0_wdata;
    w_s_mask  = bus.m0_mask;
    w_s_rstrb = 1'b0;
    w_s_wstrb = 1'b0;
    if (rst) begin
      if (w_m0_active) begin
        w_s_rstrb = bus.m0_rstrb;
        w_s_wstrb = bus.m0_wstrb;
      end else if (w_m1_gnt) begin
        w_s_addr  = bus.m1_addr;
        w_s_wdata = bus.m1_wdata;
        w_s_mask  = bus.m1_mask;
        w_s_rstrb = ~bus.m1_we;
        w_s_wstrb = bus.m1_we;
      end
    end
  end

  // Read-tracking state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Every read grant lands in RD_PEND for exactly the next cycle, which
  // is when the bus returns its data; back-to-back reads keep it there.
  always_comb begin
    w_state_next = ST_IDLE;
    if (w_m1_rd_gnt) begin
      w_state_next = ST_RD_PEND;
    end
  end

  // Capture master-1 read data so it stays visible after rvalid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m1_rdata <= '0;
    end else if (r_state == ST_RD_PEND) begin
      r_m1_rdata <= bus.s_rdata;
    end
  end

  assign w_m1_rvalid = (r_state == ST_RD_PEND);

  starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.m1_req),
    .i_gnt     (w_m1_gnt),
    .o_starved (w_starved)
  );

  assign bus.s_addr     = w_s_addr;
  assign bus.s_wdata    = w_s_wdata;
  assign bus.s_mask     = w_s_mask;
  assign bus.s_rstrb    = w_s_rstrb;
  assign bus.s_wstrb    = w_s_wstrb;
  assign bus.m0_rdata   = bus.s_rdata;
  assign bus.m1_gnt     = w_m1_gnt;
  assign bus.m1_rvalid  = w_m1_rvalid;
  assign bus.m1_rdata   = w_m1_rvalid ? bus.s_rdata : r_m1_rdata;
  assign bus.m1_starved = w_starved;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter with STARVE_LIMIT = 4. A small RAM
// model with 1-cycle read latency sits on the s_* bus. Expected read data
// is queued when a read is issued; a negedge monitor pops and compares
// whenever master 1 presents rvalid or a core read result is due.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int AW = 14;

  logic        clk;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m0Q[$];
  logic [31:0] m1Q[$];
  logic [31:0] monExp;
  logic        m0Pend;
  logic [31:0] mem [0:4095];
  logic        holdArmed;
  logic [AW+32+4:0] heldFields;

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW)) bus();

  mem_bus_arbiter #(
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (4),
    .CNT_WIDTH    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial RAM contents: each word holds 0x1000_0000 plus its word index.
  function automatic logic [31:0] ramInit(input logic [AW-1:0] addr);
    return 32'h1000_0000 | 32'(addr[AW-1:2]);
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = ramInit(AW'(i * 4));
    bus.s_rdata = '0;
  end

  // RAM/IO model: byte-masked writes, registered reads.
  always @(posedge clk) begin
    if (bus.s_wstrb === 1'b1) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.s_mask[b]) mem[bus.s_addr[AW-1:2]][b*8 +: 8] <= bus.s_wdata[b*8 +: 8];
      end
    end
    if (bus.s_rstrb === 1'b1) bus.s_rdata <= mem[bus.s_addr[AW-1:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(
    input logic m0r, input logic m0w, input logic [AW-1:0] m0a,
    input logic [31:0] m0d, input logic [3:0] m0m,
    input logic m1r, input logic m1w, input logic [AW-1:0] m1a,
    input logic [31:0] m1d, input logic [3:0] m1m);
    bus.m0_rstrb = m0r;
    bus.m0_wstrb = m0w;
    bus.m0_addr  = m0a;
    bus.m0_wdata = m0d;
    bus.m0_mask  = m0m;
    bus.m1_req   = m1r;
    bus.m1_we    = m1w;
    bus.m1_addr  = m1a;
    bus.m1_wdata = m1d;
    bus.m1_mask  = m1m;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0);
  endtask

  // Master-1 protocol watch: once a request is left waiting it must stay
  // asserted with unchanged fields until granted.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      holdArmed <= 1'b0;
    end else begin
      if (holdArmed) begin
        assert (bus.m1_req && ({bus.m1_we, bus.m1_addr, bus.m1_wdata, bus.m1_mask} == heldFields))
          else $error("[TB] master 1 changed its request before grant");
      end
      holdArmed  <= bus.m1_req && !bus.m1_gnt;
      heldFields <= {bus.m1_we, bus.m1_addr, bus.m1_wdata, bus.m1_mask};
    end
  end

  // A core read strobed in one cycle returns its data in the next.
  always @(posedge clk) m0Pend <= bus.m0_rstrb && rst;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.m1_rvalid === 1'b1) begin
      if (m1Q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL m1_rvalid_unexpected: got rvalid=1, expected no read pending at %0t", $time);
      end else begin
        monExp = m1Q.pop_front();
        checkOutput("m1_rdata", bus.m1_rdata, monExp);
      end
    end
    if (m0Pend === 1'b1) begin
      if (m0Q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL m0_rdata_unexpected: got read result, expected none at %0t", $time);
      end else begin
        monExp = m0Q.pop_front();
        checkOutput("m0_rdata", bus.m0_rdata, monExp);
      end
    end
  end

  initial begin
    logic [AW-1:0] a;

    // Reset with both masters trying to use the bus.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 14'h0010, '0, 4'hF, 1'b1, 1'b0, 14'h0100, '0, 4'hF);
    @(negedge clk);
    checkOutput("rst_gnt",     32'(bus.m1_gnt),     32'd0);
    checkOutput("rst_s_rstrb", 32'(bus.s_rstrb),    32'd0);
    checkOutput("rst_s_wstrb", 32'(bus.s_wstrb),    32'd0);
    checkOutput("rst_rvalid",  32'(bus.m1_rvalid),  32'd0);
    checkOutput("rst_starved", 32'(bus.m1_starved), 32'd0);
    checkOutput("rst_rdata",   bus.m1_rdata,        32'd0);

    nextCycle();
    rst = 1'b1;
    idle();

    // Core streams ten reads while master 1 waits on a read of 0x0100.
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      a = AW'(16 + 4 * i);
      applyStimulus(1'b1, 1'b0, a, '0, 4'hF, 1'b1, 1'b0, 14'h0100, '0, 4'hF);
      m0Q.push_back(ramInit(a));
      @(negedge clk);
      checkOutput("t1_gnt",     32'(bus.m1_gnt),     32'd0);
      checkOutput("t1_s_addr",  32'(bus.s_addr),     32'(a));
      checkOutput("t1_s_rstrb", 32'(bus.s_rstrb),    32'd1);
      checkOutput("t1_starved", 32'(bus.m1_starved), (i >= 4) ? 32'd1 : 32'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b0, 14'h0100, '0, 4'hF);
    m1Q.push_back(ramInit(14'h0100));
    @(negedge clk);
    checkOutput("t1_gnt_free",  32'(bus.m1_gnt),     32'd1);
    checkOutput("t1_m1_addr",   32'(bus.s_addr),     32'h0100);
    checkOutput("t1_m1_rstrb",  32'(bus.s_rstrb),    32'd1);
    checkOutput("t1_starv_hold", 32'(bus.m1_starved), 32'd1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t1_starv_clr", 32'(bus.m1_starved), 32'd0);

    // Master 1 writes then reads back 0x0200.
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b1, 14'h0200, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    checkOutput("t2_gnt",     32'(bus.m1_gnt),  32'd1);
    checkOutput("t2_s_wstrb", 32'(bus.s_wstrb), 32'd1);
    checkOutput("t2_s_rstrb", 32'(bus.s_rstrb), 32'd0);
    checkOutput("t2_s_addr",  32'(bus.s_addr),  32'h0200);
    checkOutput("t2_s_wdata", bus.s_wdata,      32'hDEADBEEF);
    checkOutput("t2_s_mask",  32'(bus.s_mask),  32'hF);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b0, 14'h0200, '0, 4'hF);
    m1Q.push_back(32'hDEADBEEF);
    @(negedge clk);
    checkOutput("t2_rd_gnt", 32'(bus.m1_gnt), 32'd1);
    nextCycle();
    idle();
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t2_rvalid_off", 32'(bus.m1_rvalid), 32'd0);
    checkOutput("t2_rdata_held", bus.m1_rdata,       32'hDEADBEEF);

    // Three back-to-back master-1 reads, then a core read right after.
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      a = AW'(4 * i);
      applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b0, a, '0, 4'hF);
      m1Q.push_back(ramInit(a));
      @(negedge clk);
      checkOutput("t3_gnt", 32'(bus.m1_gnt), 32'd1);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 14'h000C, '0, 4'hF, 1'b0, 1'b0, '0, '0, 4'h0);
    m0Q.push_back(ramInit(14'h000C));
    @(negedge clk);
    checkOutput("t3_rvalid_last", 32'(bus.m1_rvalid), 32'd1);
    checkOutput("t3_core_addr",   32'(bus.s_addr),    32'h000C);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t3_rvalid_off", 32'(bus.m1_rvalid), 32'd0);
    checkOutput("t3_rdata_held", bus.m1_rdata,       ramInit(14'h0008));

    // Starvation: eight core writes while master 1 keeps requesting.
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 14'h0300, 32'(k), 4'hF, 1'b1, 1'b0, 14'h0040, '0, 4'hF);
      @(negedge clk);
      checkOutput("t4_gnt",     32'(bus.m1_gnt),     32'd0);
      checkOutput("t4_starved", 32'(bus.m1_starved), (k >= 5) ? 32'd1 : 32'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b0, 14'h0040, '0, 4'hF);
    m1Q.push_back(ramInit(14'h0040));
    @(negedge clk);
    checkOutput("t4_gnt_free",  32'(bus.m1_gnt),     32'd1);
    checkOutput("t4_starv_hold", 32'(bus.m1_starved), 32'd1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t4_starv_clr", 32'(bus.m1_starved), 32'd0);

    // Reset asserted in the RD_PEND cycle drops the pending read.
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b0, 14'h0044, '0, 4'hF);
    @(negedge clk);
    checkOutput("t5_gnt", 32'(bus.m1_gnt), 32'd1);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 14'h0300, 32'h55AA55AA, 4'hF, 1'b1, 1'b0, 14'h0044, '0, 4'hF);
    @(negedge clk);
    checkOutput("t5_rvalid", 32'(bus.m1_rvalid), 32'd0);
    checkOutput("t5_s_wstrb", 32'(bus.s_wstrb),  32'd0);
    checkOutput("t5_gnt_rst", 32'(bus.m1_gnt),   32'd0);
    checkOutput("t5_rdata",   bus.m1_rdata,      32'd0);
    nextCycle();
    rst = 1'b1;
    idle();
    @(negedge clk);
    checkOutput("t5_state", 32'(dut.r_state),       32'(ST_IDLE));
    checkOutput("t5_cnt",   32'(dut.u_starve.r_cnt), 32'd0);
    checkOutput("t5_rvalid_after", 32'(bus.m1_rvalid), 32'd0);

    // Master-1 write into the IO page.
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b1, 14'h2001, 32'h0000A500, 4'b0010);
    @(negedge clk);
    checkOutput("t6_gnt",     32'(bus.m1_gnt),             32'd1);
    checkOutput("t6_s_wstrb", 32'(bus.s_wstrb),            32'd1);
    checkOutput("t6_s_rstrb", 32'(bus.s_rstrb),            32'd0);
    checkOutput("t6_io_bit",  32'(is_io_addr(bus.s_addr)), 32'd1);
    checkOutput("t6_s_addr",  32'(bus.s_addr),             32'h2001);
    checkOutput("t6_byte1",   32'(bus.s_wdata[15:8]),      32'hA5);
    checkOutput("t6_s_mask",  32'(bus.s_mask),             32'b0010);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("t6_no_rvalid", 32'(bus.m1_rvalid), 32'd0);

    // Drain and confirm every expected read was delivered.
    repeat (3) begin
      nextCycle();
      idle();
    end
    @(negedge clk);
    checkOutput("m1_queue_empty", 32'(m1Q.size()), 32'd0);
    checkOutput("m0_queue_empty", 32'(m0Q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
